// File: rtl/mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : mac_operand_feeder
// Purpose  : Upstream stage of the mac block. Buffers the A and B operand
//            streams in two small FIFOs, issues a one-cycle configuration
//            pulse per job, feeds exactly data_num operand pairs, then waits
//            for the mac result and reports job completion.
// Ports    : clk, reset (async, active-high)
//            job_start/job_float_int/job_num -> job request (sampled in IDLE)
//            job_busy/job_done               -> job status
//            a_*/b_*                         -> operand push interfaces
//            mac_config_en/mac_float_int/mac_data_num -> mac configuration
//            mac_in_a/mac_in_b/mac_in_valid_a/mac_in_valid_b -> operand issue
//            mac_out_valid/mac_out           -> mac result
//            res_data/res_valid              -> captured result
// Revision : 1.0 - initial release
// ============================================================================
module mac_operand_feeder #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_start,
    input  logic              job_float_int,
    input  logic [CNT_W-1:0]  job_num,
    output logic              job_busy,
    output logic              job_done,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
    output logic              mac_config_en,
    output logic              mac_float_int,
    output logic [CNT_W-1:0]  mac_data_num,
    output logic [DATA_W-1:0] mac_in_a,
    output logic [DATA_W-1:0] mac_in_b,
    output logic              mac_in_valid_a,
    output logic              mac_in_valid_b,
    input  logic              mac_out_valid,
    input  logic [DATA_W-1:0] mac_out,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_FCNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [c_FCNT_W-1:0] c_FCNT_ONE = {{c_PTR_W{1'b0}}, 1'b1};
    localparam logic [c_FCNT_W-1:0] c_FULL     = c_FCNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]    c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONFIG = 3'd1,
        S_FEED   = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t r_state, w_state_next;

    // Operand FIFO storage and bookkeeping
    logic [DATA_W-1:0]   r_a_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_b_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_a_wr, r_a_rd, r_b_wr, r_b_rd;
    logic [c_FCNT_W-1:0] r_a_cnt, r_b_cnt, w_a_cnt_next, w_b_cnt_next;
    logic                r_a_ready, r_b_ready;
    logic                w_a_push, w_b_push, w_pop, w_last, w_capture;

    // Job registers
    logic              r_float_int;
    logic [CNT_W-1:0]  r_num, r_issued;
    logic              r_config_en, r_in_valid, r_busy, r_done;
    logic [DATA_W-1:0] r_in_a, r_in_b, r_res_data;

    // Ready reflects the count left by the previous edge, so a push is never
    // accepted into a full FIFO even if a pop happens in the same cycle.
    assign w_a_push = a_valid && r_a_ready;
    assign w_b_push = b_valid && r_b_ready;

    assign w_pop  = (r_state == S_FEED) && (r_a_cnt != '0) && (r_b_cnt != '0)
                    && (r_issued != r_num);
    assign w_last = w_pop && ((r_issued + c_CNT_ONE) == r_num);

    // A result strobe coinciding with the last issue strobe cannot belong to
    // this job, so it is not captured.
    assign w_capture = (r_state == S_WAIT) && mac_out_valid && !r_in_valid;

    always_comb begin
        w_a_cnt_next = r_a_cnt;
        if (w_a_push && !w_pop)
            w_a_cnt_next = r_a_cnt + c_FCNT_ONE;
        else if (!w_a_push && w_pop)
            w_a_cnt_next = r_a_cnt - c_FCNT_ONE;
    end

    always_comb begin
        w_b_cnt_next = r_b_cnt;
        if (w_b_push && !w_pop)
            w_b_cnt_next = r_b_cnt + c_FCNT_ONE;
        else if (!w_b_push && w_pop)
            w_b_cnt_next = r_b_cnt - c_FCNT_ONE;
    end

    // FIFO storage carries no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (w_a_push)
            r_a_mem[r_a_wr] <= a_data;
        if (w_b_push)
            r_b_mem[r_b_wr] <= b_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_wr    <= '0;
            r_a_rd    <= '0;
            r_a_cnt   <= '0;
            r_a_ready <= 1'b1;
            r_b_wr    <= '0;
            r_b_rd    <= '0;
            r_b_cnt   <= '0;
            r_b_ready <= 1'b1;
        end else begin
            if (w_a_push)
                r_a_wr <= r_a_wr + c_PTR_ONE;
            if (w_b_push)
                r_b_wr <= r_b_wr + c_PTR_ONE;
            if (w_pop) begin
                r_a_rd <= r_a_rd + c_PTR_ONE;
                r_b_rd <= r_b_rd + c_PTR_ONE;
            end
            r_a_cnt   <= w_a_cnt_next;
            r_b_cnt   <= w_b_cnt_next;
            r_a_ready <= (w_a_cnt_next != c_FULL);
            r_b_ready <= (w_b_cnt_next != c_FULL);
        end
    end

    // Job sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (job_start)
                    w_state_next = (job_num != '0) ? S_CONFIG : S_DONE;
            end
            S_CONFIG: w_state_next = S_FEED;
            S_FEED: begin
                if (w_last)
                    w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_capture)
                    w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_float_int <= 1'b0;
            r_num       <= '0;
            r_issued    <= '0;
            r_config_en <= 1'b0;
            r_in_valid  <= 1'b0;
            r_in_a      <= '0;
            r_in_b      <= '0;
            r_res_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Zero-length jobs skip configuration, so the previous job's
            // type and length stay on the mac configuration outputs.
            if ((r_state == S_IDLE) && job_start && (job_num != '0)) begin
                r_float_int <= job_float_int;
                r_num       <= job_num;
                r_issued    <= '0;
            end
            r_config_en <= (r_state == S_CONFIG);
            r_in_valid  <= w_pop;
            if (w_pop) begin
                r_in_a   <= r_a_mem[r_a_rd];
                r_in_b   <= r_b_mem[r_b_rd];
                r_issued <= r_issued + c_CNT_ONE;
            end
            if (w_capture)
                r_res_data <= mac_out;
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (r_state == S_DONE);
        end
    end

    assign job_busy       = r_busy;
    assign job_done       = r_done;
    assign a_ready        = r_a_ready;
    assign b_ready        = r_b_ready;
    assign mac_config_en  = r_config_en;
    assign mac_float_int  = r_float_int;
    assign mac_data_num   = r_num;
    assign mac_in_a       = r_in_a;
    assign mac_in_b       = r_in_b;
    assign mac_in_valid_a = r_in_valid;
    assign mac_in_valid_b = r_in_valid;
    assign res_data       = r_res_data;
    assign res_valid      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_operand_feeder
// Purpose  : Directed self-checking bench for mac_operand_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_operand_feeder;

    logic        clk;
    logic        reset;
    logic        job_start;
    logic        job_float_int;
    logic [7:0]  job_num;
    logic        job_busy;
    logic        job_done;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic        mac_config_en;
    logic        mac_float_int;
    logic [7:0]  mac_data_num;
    logic [15:0] mac_in_a;
    logic [15:0] mac_in_b;
    logic        mac_in_valid_a;
    logic        mac_in_valid_b;
    logic        mac_out_valid;
    logic [15:0] mac_out;
    logic [15:0] res_data;
    logic        res_valid;

    int n_assert = 0;
    int n_fail   = 0;

    mac_operand_feeder #(
        .DATA_W     (16),
        .FIFO_DEPTH (4),
        .CNT_W      (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .job_start      (job_start),
        .job_float_int  (job_float_int),
        .job_num        (job_num),
        .job_busy       (job_busy),
        .job_done       (job_done),
        .a_data         (a_data),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .b_data         (b_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .mac_config_en  (mac_config_en),
        .mac_float_int  (mac_float_int),
        .mac_data_num   (mac_data_num),
        .mac_in_a       (mac_in_a),
        .mac_in_b       (mac_in_b),
        .mac_in_valid_a (mac_in_valid_a),
        .mac_in_valid_b (mac_in_valid_b),
        .mac_out_valid  (mac_out_valid),
        .mac_out        (mac_out),
        .res_data       (res_data),
        .res_valid      (res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_issue(input string tag, input logic [15:0] ea, input logic [15:0] eb);
        chk({tag, "_va"}, 32'(mac_in_valid_a), 32'd1);
        chk({tag, "_vb"}, 32'(mac_in_valid_b), 32'd1);
        chk({tag, "_a"}, 32'(mac_in_a), 32'(ea));
        chk({tag, "_b"}, 32'(mac_in_b), 32'(eb));
    endtask

    // One quiet WAIT cycle, then a result strobe, then the completion pulse.
    task automatic finish_job(input string tag, input logic [15:0] val);
        tick();
        chk({tag, "_wait_done"}, 32'(job_done), 32'd0);
        chk({tag, "_wait_busy"}, 32'(job_busy), 32'd1);
        chk({tag, "_wait_iv"}, 32'(mac_in_valid_a), 32'd0);
        mac_out_valid = 1'b1;
        mac_out       = val;
        tick();
        mac_out_valid = 1'b0;
        mac_out       = 16'h0;
        chk({tag, "_cap_done"}, 32'(job_done), 32'd0);
        chk({tag, "_cap_res"}, 32'(res_data), 32'(val));
        tick();
        chk({tag, "_done"}, 32'(job_done), 32'd1);
        chk({tag, "_rvalid"}, 32'(res_valid), 32'd1);
        chk({tag, "_busy_off"}, 32'(job_busy), 32'd0);
        chk({tag, "_res_held"}, 32'(res_data), 32'(val));
        tick();
        chk({tag, "_done_off"}, 32'(job_done), 32'd0);
        chk({tag, "_rvalid_off"}, 32'(res_valid), 32'd0);
    endtask

    task automatic push_pair(input logic [15:0] va, input logic [15:0] vb);
        a_valid = 1'b1;
        a_data  = va;
        b_valid = 1'b1;
        b_data  = vb;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        job_start     = 1'b0;
        job_float_int = 1'b0;
        job_num       = 8'd0;
        a_data        = 16'h0;
        a_valid       = 1'b0;
        b_data        = 16'h0;
        b_valid       = 1'b0;
        mac_out_valid = 1'b0;
        mac_out       = 16'h0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_busy", 32'(job_busy), 32'd0);
        chk("rst_done", 32'(job_done), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        chk("rst_cfg", 32'(mac_config_en), 32'd0);
        chk("rst_iv", 32'(mac_in_valid_a), 32'd0);
        chk("rst_num", 32'(mac_data_num), 32'd0);
        chk("rst_res", 32'(res_data), 32'd0);
        chk("rst_rvalid", 32'(res_valid), 32'd0);
        reset = 1'b0;

        // ---------------- job 1: prefetched, num = 4 ----------------
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_data  = 16'(i + 1);
            b_valid = 1'b1;
            b_data  = 16'(i + 5);
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("j1_a_full", 32'(a_ready), 32'd0);
        chk("j1_b_full", 32'(b_ready), 32'd0);
        job_start     = 1'b1;
        job_num       = 8'd4;
        job_float_int = 1'b0;
        tick();
        job_start = 1'b0;
        chk("j1_busy", 32'(job_busy), 32'd1);
        chk("j1_cfg_early", 32'(mac_config_en), 32'd0);
        tick();
        chk("j1_cfg", 32'(mac_config_en), 32'd1);
        chk("j1_num", 32'(mac_data_num), 32'd4);
        chk("j1_fi", 32'(mac_float_int), 32'd0);
        chk("j1_iv_early", 32'(mac_in_valid_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_issue("j1_issue", 16'(i + 1), 16'(i + 5));
            if (i == 0) begin
                chk("j1_cfg_off", 32'(mac_config_en), 32'd0);
                chk("j1_a_ready_back", 32'(a_ready), 32'd1);
            end
        end
        finish_job("j1", 16'd70);

        // ---------------- job 2: B trickles in, num = 3 ----------------
        for (int t = 0; t < 11; t++) begin
            job_start     = (t == 0);
            job_num       = 8'd3;
            job_float_int = 1'b0;
            a_valid       = (t < 3);
            a_data        = 16'(10 + t);
            b_valid       = (t == 4) || (t == 6) || (t == 8);
            b_data        = 16'(20 + t);
            tick();
            if (t == 5)
                chk_issue("j2_issue0", 16'd10, 16'd24);
            else if (t == 7)
                chk_issue("j2_issue1", 16'd11, 16'd26);
            else if (t == 9)
                chk_issue("j2_issue2", 16'd12, 16'd28);
            else
                chk("j2_no_issue", 32'(mac_in_valid_a), 32'd0);
        end
        job_start = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        chk("j2_wait_iv", 32'(mac_in_valid_b), 32'd0);
        mac_out_valid = 1'b1;
        mac_out       = 16'h0055;
        tick();
        mac_out_valid = 1'b0;
        tick();
        chk("j2_done", 32'(job_done), 32'd1);
        chk("j2_res", 32'(res_data), 32'h55);
        tick();

        // ---------------- job 3: full FIFO, push during pop ----------------
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_data  = 16'(30 + i);
            b_valid = 1'b1;
            b_data  = 16'(40 + i);
            tick();
        end
        chk("j3_a_full", 32'(a_ready), 32'd0);
        b_valid   = 1'b0;
        a_data    = 16'd34;
        job_start = 1'b1;
        job_num   = 8'd4;
        tick();
        job_start = 1'b0;
        chk("j3_a_full_cfg", 32'(a_ready), 32'd0);
        tick();
        chk("j3_a_full_feed", 32'(a_ready), 32'd0);
        tick();
        chk_issue("j3_issue0", 16'd30, 16'd40);
        chk("j3_a_ready_back", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        chk_issue("j3_issue1", 16'd31, 16'd41);
        chk("j3_a_ready_pp", 32'(a_ready), 32'd1);
        tick();
        chk_issue("j3_issue2", 16'd32, 16'd42);
        tick();
        chk_issue("j3_issue3", 16'd33, 16'd43);
        finish_job("j3", 16'h0123);

        // ---------------- job 4: leftover A entry, float, num = 1 ----------------
        b_valid = 1'b1;
        b_data  = 16'd44;
        tick();
        b_valid       = 1'b0;
        job_start     = 1'b1;
        job_num       = 8'd1;
        job_float_int = 1'b1;
        tick();
        job_start = 1'b0;
        tick();
        chk("j4_cfg", 32'(mac_config_en), 32'd1);
        chk("j4_fi", 32'(mac_float_int), 32'd1);
        chk("j4_num", 32'(mac_data_num), 32'd1);
        tick();
        chk_issue("j4_issue", 16'd34, 16'd44);
        finish_job("j4", 16'h0456);

        // ---------------- zero-length job ----------------
        job_start     = 1'b1;
        job_num       = 8'd0;
        job_float_int = 1'b0;
        tick();
        job_start = 1'b0;
        chk("z_busy", 32'(job_busy), 32'd1);
        chk("z_cfg0", 32'(mac_config_en), 32'd0);
        chk("z_done_early", 32'(job_done), 32'd0);
        tick();
        chk("z_done", 32'(job_done), 32'd1);
        chk("z_rvalid", 32'(res_valid), 32'd1);
        chk("z_res", 32'(res_data), 32'h0456);
        chk("z_cfg1", 32'(mac_config_en), 32'd0);
        chk("z_iv", 32'(mac_in_valid_a), 32'd0);
        chk("z_num_held", 32'(mac_data_num), 32'd1);
        tick();
        chk("z_done_off", 32'(job_done), 32'd0);

        // ---------------- reset during FEED ----------------
        for (int i = 0; i < 4; i++)
            push_pair(16'(50 + i), 16'(60 + i));
        job_start = 1'b1;
        job_num   = 8'd4;
        tick();
        job_start = 1'b0;
        tick();
        tick();
        chk_issue("r_issue0", 16'd50, 16'd60);
        tick();
        chk_issue("r_issue1", 16'd51, 16'd61);
        reset = 1'b1;
        #2;
        chk("r_busy", 32'(job_busy), 32'd0);
        chk("r_iv", 32'(mac_in_valid_a), 32'd0);
        chk("r_in_a", 32'(mac_in_a), 32'd0);
        chk("r_a_ready", 32'(a_ready), 32'd1);
        chk("r_b_ready", 32'(b_ready), 32'd1);
        chk("r_num", 32'(mac_data_num), 32'd0);
        chk("r_res", 32'(res_data), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("r_done_none", 32'(job_done), 32'd0);
        push_pair(16'd70, 16'd71);
        job_start = 1'b1;
        job_num   = 8'd1;
        tick();
        job_start = 1'b0;
        tick();
        chk("r2_cfg", 32'(mac_config_en), 32'd1);
        tick();
        chk_issue("r2_issue", 16'd70, 16'd71);
        finish_job("r2", 16'h0099);

        // ---------------- ignored events ----------------
        mac_out_valid = 1'b1;
        mac_out       = 16'h1234;
        tick();
        mac_out_valid = 1'b0;
        chk("ig_idle_res", 32'(res_data), 32'h0099);
        chk("ig_idle_done", 32'(job_done), 32'd0);
        a_valid = 1'b1;
        a_data  = 16'd2;
        tick();
        a_valid   = 1'b0;
        job_start = 1'b1;
        job_num   = 8'd1;
        tick();
        job_start = 1'b0;
        tick();
        chk("ig_cfg", 32'(mac_config_en), 32'd1);
        mac_out_valid = 1'b1;
        mac_out       = 16'h1111;
        tick();
        mac_out_valid = 1'b0;
        chk("ig_feed_iv", 32'(mac_in_valid_a), 32'd0);
        b_valid = 1'b1;
        b_data  = 16'd3;
        tick();
        b_valid = 1'b0;
        chk("ig_feed_res", 32'(res_data), 32'h0099);
        chk("ig_feed_done", 32'(job_done), 32'd0);
        tick();
        chk_issue("ig_issue", 16'd2, 16'd3);
        job_start = 1'b1;
        job_num   = 8'd5;
        tick();
        job_start = 1'b0;
        tick();
        chk("ig_wait_cfg", 32'(mac_config_en), 32'd0);
        chk("ig_wait_busy", 32'(job_busy), 32'd1);
        chk("ig_wait_done", 32'(job_done), 32'd0);
        finish_job("ig", 16'd6);
        chk("ig_after_cfg", 32'(mac_config_en), 32'd0);
        chk("ig_after_busy", 32'(job_busy), 32'd0);
        chk("ig_after_num", 32'(mac_data_num), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
